// File: rtl/ps2_scancode_fifo_pkg.sv
// ---- ps2_scancode_fifo_pkg : shared register map, status layout and queue entry (rev 1.0) ----
`default_nettype none

package ps2_scancode_fifo_pkg;

  localparam logic [7:0] ADDR_SCANCODE = 8'h04;
  localparam logic [7:0] ADDR_KBSTATUS = 8'h05;
  localparam logic [7:0] ADDR_KBCOUNT  = 8'h06;

  localparam int ST_PEN  = 0;
  localparam int ST_EXT  = 1;
  localparam int ST_RLS  = 2;
  localparam int ST_ERR  = 3;
  localparam int ST_FULL = 5;
  localparam int ST_OVF  = 6;
  localparam int ST_BSY  = 7;

  localparam int CTRL_OVF_CLR = 6;
  localparam int CTRL_FLUSH   = 7;

  localparam int ENTRY_W = 10;

  typedef struct packed {
    logic       ext;
    logic       rls;
    logic [7:0] code;
  } entry_t;

  function automatic logic [7:0] pack_status(input logic bsy, input logic ovf,
                                             input logic full, input logic err,
                                             input logic rls, input logic ext,
                                             input logic pen);
    logic [7:0] s;
    s          = '0;
    s[ST_BSY]  = bsy;
    s[ST_OVF]  = ovf;
    s[ST_FULL] = full;
    s[ST_ERR]  = err;
    s[ST_RLS]  = rls;
    s[ST_EXT]  = ext;
    s[ST_PEN]  = pen;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_scancode_fifo_if.sv
// ---- ps2_scancode_fifo_if : PS/2 event input plus ZX-UNO register bus (rev 1.0) ----
`default_nettype none

interface ps2_scancode_fifo_if;
  logic       kb_interrupt;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       ps2busy;
  logic       kberror;
  logic [7:0] zxuno_addr;
  logic       zxuno_regrd;
  logic       zxuno_regwr;
  logic [7:0] din;
  logic [7:0] scancode_dout;
  logic       oe_n_scancode;
  logic [7:0] kbstatus_dout;
  logic       oe_n_kbstatus;
  logic [7:0] count_dout;
  logic       oe_n_count;
  logic       irq_n;

  modport master (
    output kb_interrupt, scancode, extended, released, ps2busy, kberror,
           zxuno_addr, zxuno_regrd, zxuno_regwr, din,
    input  scancode_dout, oe_n_scancode, kbstatus_dout, oe_n_kbstatus,
           count_dout, oe_n_count, irq_n
  );

  modport slave (
    input  kb_interrupt, scancode, extended, released, ps2busy, kberror,
           zxuno_addr, zxuno_regrd, zxuno_regwr, din,
    output scancode_dout, oe_n_scancode, kbstatus_dout, oe_n_kbstatus,
           count_dout, oe_n_count, irq_n
  );
endinterface

`default_nettype wire

// File: rtl/ps2_scancode_fifo_event_fifo.sv
// ---- ps2_scancode_fifo_event_fifo : generic sync FIFO with flush and registered head (rev 1.0) ----
`default_nettype none

module ps2_scancode_fifo_event_fifo #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] w_rd_ptr_nxt;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_nxt;
  logic [WIDTH-1:0]      r_head;
  logic [WIDTH-1:0]      w_head_nxt;
  logic                  w_do_pop;
  logic                  w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Head is precomputed so it is valid the cycle after the push/pop lands;
  // a push landing on the new read slot bypasses the memory.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr + DEPTH_LOG2'(w_do_pop);
    w_count_nxt  = r_count + CW'(w_do_push) - CW'(w_do_pop);
    w_head_nxt   = '0;
    if (w_count_nxt != '0) begin
      if (w_do_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
        w_head_nxt = push_data;
      end else begin
        w_head_nxt = mem[w_rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) begin
      mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(w_do_push);
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
    end
  end

  assign head  = r_head;
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ps2_scancode_fifo.sv
// ---- ps2_scancode_fifo : queued PS/2 scancode/status/count registers for ZX-UNO (rev 1.0) ----
`default_nettype none

module ps2_scancode_fifo
  import ps2_scancode_fifo_pkg::*;
#(
  parameter int         DEPTH_LOG2     = 4,
  parameter bit         DROP_TYPEMATIC = 1'b1,
  parameter logic [7:0] SCANCODE       = ADDR_SCANCODE,
  parameter logic [7:0] KBSTATUS       = ADDR_KBSTATUS,
  parameter logic [7:0] KBCOUNT        = ADDR_KBCOUNT
) (
  input  logic               clk,
  input  logic               rst_n,
  ps2_scancode_fifo_if.slave bus
);

  logic                r_rd_d;
  logic                r_wr_d;
  logic                r_rd_sc;
  logic                r_rd_st;
  logic                r_ovf;
  logic                r_bsy;
  logic                r_err;
  logic [8:0]          r_trk;
  logic                r_trk_vld;
  logic                w_rd_rise;
  logic                w_rd_fall;
  logic                w_pop;
  logic                w_st_rd_done;
  logic                w_wr_rise;
  logic                w_flush;
  logic                w_ovf_wr_clr;
  logic                w_ovf_set;
  logic                w_match;
  logic                w_filtered;
  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic [DEPTH_LOG2:0] w_count;
  entry_t              w_entry;
  entry_t              w_head;
  logic                w_unused;

  assign w_unused     = ^bus.din[5:0];

  assign w_rd_rise    = bus.zxuno_regrd & ~r_rd_d;
  assign w_rd_fall    = r_rd_d & ~bus.zxuno_regrd;
  assign w_pop        = w_rd_fall & r_rd_sc;
  assign w_st_rd_done = w_rd_fall & r_rd_st;
  assign w_wr_rise    = bus.zxuno_regwr & ~r_wr_d & (bus.zxuno_addr == KBSTATUS);
  assign w_flush      = w_wr_rise & bus.din[CTRL_FLUSH];
  assign w_ovf_wr_clr = w_wr_rise & bus.din[CTRL_OVF_CLR];

  assign w_entry      = {bus.extended, bus.released, bus.scancode};
  assign w_match      = r_trk_vld & (r_trk == {bus.extended, bus.scancode});
  assign w_filtered   = DROP_TYPEMATIC & ~bus.released & w_match;
  assign w_push       = bus.kb_interrupt & ~w_filtered;
  // A full queue is never empty, so any pop request frees a slot for the push.
  assign w_ovf_set    = w_push & w_full & ~w_pop & ~w_flush;

  // Strobe history resets high so a strobe still asserted when reset lifts
  // is not mistaken for a fresh access and cannot pop on its falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_d    <= 1'b1;
      r_wr_d    <= 1'b1;
      r_rd_sc   <= 1'b0;
      r_rd_st   <= 1'b0;
      r_ovf     <= 1'b0;
      r_bsy     <= 1'b0;
      r_err     <= 1'b0;
      r_trk     <= '0;
      r_trk_vld <= 1'b0;
    end else begin
      r_rd_d <= bus.zxuno_regrd;
      r_wr_d <= bus.zxuno_regwr;
      r_bsy  <= bus.ps2busy;
      r_err  <= bus.kberror;

      if (w_rd_rise) begin
        r_rd_sc <= (bus.zxuno_addr == SCANCODE);
        r_rd_st <= (bus.zxuno_addr == KBSTATUS);
      end else if (w_rd_fall) begin
        r_rd_sc <= 1'b0;
        r_rd_st <= 1'b0;
      end

      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_wr_clr || w_st_rd_done) begin
        r_ovf <= 1'b0;
      end

      if (w_flush) begin
        r_trk_vld <= 1'b0;
      end else if (bus.kb_interrupt && DROP_TYPEMATIC) begin
        if (!bus.released) begin
          if (!w_filtered) begin
            r_trk     <= {bus.extended, bus.scancode};
            r_trk_vld <= 1'b1;
          end
        end else if (w_match) begin
          r_trk_vld <= 1'b0;
        end
      end
    end
  end

  ps2_scancode_fifo_event_fifo #(
    .WIDTH      (ENTRY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (w_flush),
    .push      (w_push),
    .push_data (w_entry),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign bus.scancode_dout = w_head.code;
  assign bus.kbstatus_dout = pack_status(r_bsy, r_ovf, w_full, r_err,
                                         w_head.rls, w_head.ext, ~w_empty);
  assign bus.count_dout    = 8'(w_count);
  assign bus.irq_n         = ~(~w_empty | r_ovf);

  assign bus.oe_n_scancode = ~(bus.zxuno_regrd & (bus.zxuno_addr == SCANCODE));
  assign bus.oe_n_kbstatus = ~(bus.zxuno_regrd & (bus.zxuno_addr == KBSTATUS));
  assign bus.oe_n_count    = ~(bus.zxuno_regrd & (bus.zxuno_addr == KBCOUNT));

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_fifo.sv
// ---- tb_ps2_scancode_fifo : directed vector bench for ps2_scancode_fifo (rev 1.0) ----
`default_nettype none

module tb_ps2_scancode_fifo;

  localparam int OP_PUSH = 0;
  localparam int OP_RDSC = 1;
  localparam int OP_RDST = 2;
  localparam int OP_WRST = 3;
  localparam int NVEC    = 14;

  typedef struct {
    int         op;
    logic [7:0] arg;
    logic [1:0] fl;       // {ext, rls}
    logic [7:0] exp_cnt;
    logic [7:0] exp_st;
    logic [7:0] exp_sc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kb_interrupt = 1'b0;
  logic [7:0] code = 8'h00;
  logic       ext = 1'b0;
  logic       rls = 1'b0;
  logic       ps2busy = 1'b0;
  logic       kberror = 1'b0;
  logic [7:0] addr = 8'h00;
  logic       regrd = 1'b0;
  logic       regwr = 1'b0;
  logic [7:0] din = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs [NVEC];

  ps2_scancode_fifo_if bus ();
  ps2_scancode_fifo_if bus_nf ();

  assign bus.kb_interrupt    = kb_interrupt;
  assign bus.scancode        = code;
  assign bus.extended        = ext;
  assign bus.released        = rls;
  assign bus.ps2busy         = ps2busy;
  assign bus.kberror         = kberror;
  assign bus.zxuno_addr      = addr;
  assign bus.zxuno_regrd     = regrd;
  assign bus.zxuno_regwr     = regwr;
  assign bus.din             = din;
  assign bus_nf.kb_interrupt = kb_interrupt;
  assign bus_nf.scancode     = code;
  assign bus_nf.extended     = ext;
  assign bus_nf.released     = rls;
  assign bus_nf.ps2busy      = ps2busy;
  assign bus_nf.kberror      = kberror;
  assign bus_nf.zxuno_addr   = addr;
  assign bus_nf.zxuno_regrd  = regrd;
  assign bus_nf.zxuno_regwr  = regwr;
  assign bus_nf.din          = din;

  ps2_scancode_fifo #(.DEPTH_LOG2(4), .DROP_TYPEMATIC(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ps2_scancode_fifo #(.DEPTH_LOG2(4), .DROP_TYPEMATIC(1'b0)) u_dut_nf (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_nf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic push_ev(input logic [7:0] c, input logic e, input logic r);
    kb_interrupt = 1'b1;
    code = c;
    ext = e;
    rls = r;
    step();
    kb_interrupt = 1'b0;
    ext = 1'b0;
    rls = 1'b0;
  endtask

  task automatic read_reg(input logic [7:0] a, input int n);
    addr = a;
    regrd = 1'b1;
    repeat (n) step();
    regrd = 1'b0;
    step();
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    addr = a;
    din = d;
    regwr = 1'b1;
    step();
    step();
    regwr = 1'b0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{OP_PUSH, 8'h1C, 2'b00, 8'd1, 8'h01, 8'h1C};
    vecs[1]  = '{OP_PUSH, 8'h32, 2'b00, 8'd2, 8'h01, 8'h1C};
    vecs[2]  = '{OP_PUSH, 8'h1C, 2'b01, 8'd3, 8'h01, 8'h1C};
    vecs[3]  = '{OP_RDSC, 8'h00, 2'b00, 8'd2, 8'h01, 8'h32};
    vecs[4]  = '{OP_RDSC, 8'h00, 2'b00, 8'd1, 8'h05, 8'h1C};
    vecs[5]  = '{OP_RDSC, 8'h00, 2'b00, 8'd0, 8'h00, 8'h00};
    vecs[6]  = '{OP_PUSH, 8'h75, 2'b10, 8'd1, 8'h03, 8'h75};
    vecs[7]  = '{OP_RDST, 8'h00, 2'b00, 8'd1, 8'h03, 8'h75};
    vecs[8]  = '{OP_WRST, 8'h80, 2'b00, 8'd0, 8'h00, 8'h00};
    vecs[9]  = '{OP_PUSH, 8'h75, 2'b10, 8'd1, 8'h03, 8'h75};
    vecs[10] = '{OP_PUSH, 8'h75, 2'b10, 8'd1, 8'h03, 8'h75};
    vecs[11] = '{OP_PUSH, 8'h75, 2'b11, 8'd2, 8'h03, 8'h75};
    vecs[12] = '{OP_PUSH, 8'h75, 2'b10, 8'd3, 8'h03, 8'h75};
    vecs[13] = '{OP_WRST, 8'h80, 2'b00, 8'd0, 8'h00, 8'h00};

    repeat (3) step();
    check("reset count", bus.count_dout, 8'h00);
    check("reset status", bus.kbstatus_dout, 8'h00);
    check("reset scancode", bus.scancode_dout, 8'h00);
    check("reset irq_n", {7'd0, bus.irq_n}, 8'h01);
    check("reset oe_n", {5'd0, bus.oe_n_scancode, bus.oe_n_kbstatus, bus.oe_n_count}, 8'h07);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NVEC; i++) begin
      case (vecs[i].op)
        OP_PUSH: push_ev(vecs[i].arg, vecs[i].fl[1], vecs[i].fl[0]);
        OP_RDSC: read_reg(8'h04, 2);
        OP_RDST: read_reg(8'h05, 2);
        default: write_reg(8'h05, vecs[i].arg);
      endcase
      check($sformatf("vec%0d count", i), bus.count_dout, vecs[i].exp_cnt);
      check($sformatf("vec%0d status", i), bus.kbstatus_dout, vecs[i].exp_st);
      check($sformatf("vec%0d scancode", i), bus.scancode_dout, vecs[i].exp_sc);
      check($sformatf("vec%0d irq_n", i), {7'd0, bus.irq_n},
            (vecs[i].exp_cnt == 8'd0) ? 8'h01 : 8'h00);
    end

    // Overflow: 17 pushes into 16 slots
    for (int i = 0; i < 17; i++) push_ev(8'(8'h10 + i), 1'b0, 1'b0);
    check("ovf count", bus.count_dout, 8'd16);
    check("ovf status", bus.kbstatus_dout, 8'h61);
    check("ovf irq_n", {7'd0, bus.irq_n}, 8'h00);
    write_reg(8'h05, 8'h40);
    check("ovf clear status", bus.kbstatus_dout, 8'h21);

    // Push coinciding with a SCANCODE pop while full
    addr = 8'h04;
    regrd = 1'b1;
    step();
    step();
    regrd = 1'b0;
    kb_interrupt = 1'b1;
    code = 8'h30;
    step();
    kb_interrupt = 1'b0;
    check("full pushpop count", bus.count_dout, 8'd16);
    check("full pushpop status", bus.kbstatus_dout, 8'h21);
    check("full pushpop head", bus.scancode_dout, 8'h11);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d", i), bus.scancode_dout, (i < 15) ? 8'(8'h11 + i) : 8'h30);
      read_reg(8'h04, 1);
    end
    check("drain count", bus.count_dout, 8'd0);
    check("drain status", bus.kbstatus_dout, 8'h00);

    // Typematic repeat of a held key
    write_reg(8'h05, 8'hC0);
    repeat (5) push_ev(8'h1C, 1'b0, 1'b0);
    push_ev(8'h1C, 1'b0, 1'b1);
    check("typematic filtered count", bus.count_dout, 8'd2);
    check("typematic unfiltered count", bus_nf.count_dout, 8'd6);
    read_reg(8'h04, 1);
    check("typematic release status", bus.kbstatus_dout, 8'h05);

    // Flush beats a same-cycle push
    write_reg(8'h05, 8'hC0);
    for (int i = 0; i < 5; i++) push_ev(8'(8'h41 + i), 1'b0, 1'b0);
    check("pre-flush count", bus.count_dout, 8'd5);
    addr = 8'h05;
    din = 8'h80;
    regwr = 1'b1;
    kb_interrupt = 1'b1;
    code = 8'h46;
    step();
    kb_interrupt = 1'b0;
    step();
    regwr = 1'b0;
    step();
    check("flush count", bus.count_dout, 8'd0);
    check("flush irq_n", {7'd0, bus.irq_n}, 8'h01);
    check("flush scancode", bus.scancode_dout, 8'h00);
    check("flush status", bus.kbstatus_dout, 8'h00);

    // Long strobe: one pop only
    push_ev(8'h51, 1'b0, 1'b0);
    push_ev(8'h52, 1'b0, 1'b0);
    addr = 8'h04;
    regrd = 1'b1;
    repeat (20) step();
    check("long read hold count", bus.count_dout, 8'd2);
    check("long read oe_n", {5'd0, bus.oe_n_scancode, bus.oe_n_kbstatus, bus.oe_n_count}, 8'h03);
    regrd = 1'b0;
    step();
    check("long read count", bus.count_dout, 8'd1);
    check("long read head", bus.scancode_dout, 8'h52);
    repeat (3) step();
    check("long read no extra pop", bus.count_dout, 8'd1);

    // Reset in the middle of a SCANCODE read
    regrd = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    step();
    check("mid-read reset count", bus.count_dout, 8'd0);
    check("mid-read reset scancode", bus.scancode_dout, 8'h00);
    rst_n = 1'b1;
    push_ev(8'h61, 1'b0, 1'b0);
    check("post-reset push count", bus.count_dout, 8'd1);
    regrd = 1'b0;
    step();
    step();
    check("post-reset no pop count", bus.count_dout, 8'd1);
    check("post-reset head", bus.scancode_dout, 8'h61);

    // BSY/ERR passthrough
    ps2busy = 1'b1;
    kberror = 1'b1;
    step();
    check("bsy err status", bus.kbstatus_dout, 8'h89);
    ps2busy = 1'b0;
    kberror = 1'b0;
    step();
    check("bsy err cleared", bus.kbstatus_dout, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
